mem_responder: RTL

- Memory-side responder for the 8-bit CPU's control-unit memory strobes (mem_read, mem_write, mem2bus, bus2mem).
- Holds program/data RAM, addressed by the AR output.
- Services one read or write per request, with a configurable number of wait states.
- Drives the data bus on reads, reports completion via mem_ready, and flags illegal requests.

---
 rtl/mem_pkg.sv | 9 +
 rtl/mem_array.sv | 22 ++
 rtl/mem_responder.sv | 95 +++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared state/op encodings and default sizing for the memory responder
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_OOR, OP_ERR} op_t;
  localparam int ADDR_W_D   = 16;
  localparam int DATA_W_D   = 8;
  localparam int DEPTH_D    = 256;
  localparam int WAIT_CNT_W = 4;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM with registered, clearable read data
module mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     re,
  input  logic                     clr,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] ram [DEPTH];
  // storage is never cleared; only the write strobe touches it
  always_ff @(posedge clk)
    if (we) ram[addr] <= wdata;
  // read register holds the last completed read; out-of-range reads load zero
  always_ff @(posedge clk)
    rdata <= (!rst || clr) ? '0 : re ? ram[addr] : rdata;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: services CPU memory strobes with wait states; optional MEM_LOAD_PORT_EN adds a direct load port
module mem_responder import mem_pkg::*; #(
  parameter int ADDR_W   = ADDR_W_D,
  parameter int DATA_W   = DATA_W_D,
  parameter int DEPTH    = DEPTH_D,
  parameter int WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              bus2mem,
  input  logic              mem2bus,
  input  logic [DATA_W-1:0] wdata,
`ifdef MEM_LOAD_PORT_EN
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
`endif
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              mem_ready,
  output logic              err,
  output logic              busy
);
  localparam int AW = $clog2(DEPTH);
  state_t                state;
  op_t                   op_q, op_d, op;
  logic [AW-1:0]         addr_q, ld_a, ram_a;
  logic [DATA_W-1:0]     wdata_q, ld_d, ram_d, rdata;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  req, ld, ld_ok, fire;
`ifdef MEM_LOAD_PORT_EN
  assign ld    = load_en && state == IDLE;
  assign ld_ok = load_addr < ADDR_W'(DEPTH);
  assign ld_a  = load_addr[AW-1:0];
  assign ld_d  = load_data;
`else
  assign ld    = 1'b0;
  assign ld_ok = 1'b0;
  assign ld_a  = '0;
  assign ld_d  = '0;
`endif
  // classify the request; in IDLE act on live inputs so zero-wait completes at the accept edge
  always_comb begin
    req   = mem_read | mem_write;
    op_d  = addr >= ADDR_W'(DEPTH) ? (mem_read && !mem_write ? OP_OOR : OP_ERR)
          : mem_read && !mem_write ? OP_RD
          : mem_write && !mem_read && bus2mem ? OP_WR : OP_ERR;
    op    = state == IDLE ? op_d : op_q;
    fire  = state == IDLE ? req && !ld && WAIT_CYC == 0 : state == WAIT && wait_cnt == '0;
    ram_a = ld ? ld_a : state == IDLE ? addr[AW-1:0] : addr_q;
    ram_d = ld ? ld_d : state == IDLE ? wdata : wdata_q;
  end
  mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (rst && (ld ? ld_ok : fire && op == OP_WR)),
    .re    (fire && op == OP_RD),
    .clr   (fire && op == OP_OOR),
    .addr  (ram_a),
    .wdata (ram_d),
    .rdata (rdata)
  );
  assign bus_out = mem2bus ? rdata : '0;
  assign bus_oe  = mem2bus;
  // request FSM with registered completion, error and busy flags
  always_ff @(posedge clk)
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      mem_ready <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_ready <= fire;
      err       <= ld ? !ld_ok : fire && (op == OP_ERR || op == OP_OOR);
      busy      <= state == IDLE ? req && !ld : state == WAIT;
      case (state)
        IDLE: if (req && !ld) begin
          op_q     <= op_d;
          addr_q   <= addr[AW-1:0];
          wdata_q  <= wdata;
          state    <= WAIT_CYC == 0 ? DONE : WAIT;
          wait_cnt <= WAIT_CNT_W'(WAIT_CYC - 1);
        end
        WAIT: begin
          state    <= wait_cnt == '0 ? DONE : WAIT;
          wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
endmodule
